// File: rtl/ppa_pkg.sv
// Shared widths and the stage-1 payload type for the shared approximate adder.
package ppa_pkg;

  localparam int WIDTH    = 16;
  localparam int APPROX_K = 8;
  localparam int NUM_REQ  = 4;
  localparam int ID_W     = $clog2(NUM_REQ);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             exact;
  } s1_pld_t;

endpackage

// File: rtl/bk_approx_core.sv
// Combinational adder: approximate sum (low carries truncated to one bit of
// look-back below APPROX_K, Brent-Kung prefix above it) alongside the exact sum.
module bk_approx_core
  import ppa_pkg::*;
#(
  parameter int WIDTH    = ppa_pkg::WIDTH,
  parameter int APPROX_K = ppa_pkg::APPROX_K
)(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] approx_sum_o,
  output logic             approx_cout_o,
  output logic [WIDTH-1:0] exact_sum_o,
  output logic             exact_cout_o
);

  localparam int N  = WIDTH - APPROX_K;
  localparam int LG = (N > 1) ? $clog2(N) : 0;

  logic [WIDTH-1:0] p, g;
  logic [N-1:0]     gg, pp;
  logic [WIDTH:0]   c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  always_comb begin
    gg = g[WIDTH-1:APPROX_K];
    pp = p[WIDTH-1:APPROX_K];
    // Fold the restart carry (g[K-1]) into the lowest prefix node.
    gg[0] = g[APPROX_K] | (p[APPROX_K] & g[APPROX_K-1]);
    for (int d = 0; d < LG; d++) begin
      for (int i = 0; i < N; i++) begin
        if (i >= (1 << d) && ((i + 1) % (2 << d)) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
          pp[i] = pp[i] & pp[i - (1 << d)];
        end
      end
    end
    for (int d = LG - 2; d >= 0; d--) begin
      for (int i = 0; i < N; i++) begin
        if (i >= (3 << d) - 1 && ((i + 1) % (2 << d)) == (1 << d)) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
          pp[i] = pp[i] & pp[i - (1 << d)];
        end
      end
    end
    c = '0;
    for (int j = 1; j <= APPROX_K; j++) c[j] = g[j-1];
    for (int i = 0; i < N; i++) c[APPROX_K+i+1] = gg[i];
  end

  assign approx_sum_o  = p ^ c[WIDTH-1:0];
  assign approx_cout_o = c[WIDTH];

  assign {exact_cout_o, exact_sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/ppa_adder_arbiter.sv
// Round-robin front end and two-stage valid/ready pipeline around one shared
// approximate adder, with a saturating count of approximate-result errors.
module ppa_adder_arbiter
  import ppa_pkg::*;
#(
  parameter int  NUM_REQ  = ppa_pkg::NUM_REQ,
  parameter int  WIDTH    = ppa_pkg::WIDTH,
  parameter int  APPROX_K = ppa_pkg::APPROX_K,
  localparam int ID_W     = $clog2(NUM_REQ)
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]       req_cin_i,
  input  logic [NUM_REQ-1:0]       req_exact_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [WIDTH-1:0]         rsp_sum_o,
  output logic                     rsp_cout_o,
  output logic                     rsp_err_o,
  input  logic                     err_clr_i,
  output logic [15:0]              err_count_o
);

  s1_pld_t          s1_q, s1_d;
  logic             s1_vld_q, s1_vld_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_err_q, rsp_err_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any, s2_load, s1_load, accept, core_err, err_inc;
  logic [WIDTH-1:0] a_sum, e_sum;
  logic             a_cout, e_cout;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_any && req_valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign s2_load     = !rsp_valid_q || rsp_ready_i;
  assign s1_load     = !s1_vld_q || s2_load;
  assign accept      = gnt_any && s1_load && !rst;
  assign req_ready_o = {{(NUM_REQ-1){1'b0}}, accept} << gnt_id;

  // Approximate ops run the core at cin=0 so its exact output is the error reference.
  bk_approx_core #(.WIDTH(WIDTH), .APPROX_K(APPROX_K)) u_core (
    .a_i          (s1_q.a),
    .b_i          (s1_q.b),
    .cin_i        (s1_q.exact & s1_q.cin),
    .approx_sum_o (a_sum),
    .approx_cout_o(a_cout),
    .exact_sum_o  (e_sum),
    .exact_cout_o (e_cout)
  );

  assign core_err = !s1_q.exact && ({a_cout, a_sum} != {e_cout, e_sum});
  assign err_inc  = s2_load && s1_vld_q && core_err;

  always_comb begin
    s1_d        = s1_q;
    s1_vld_d    = s1_vld_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    if (s2_load) begin
      rsp_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        rsp_id_d   = s1_q.id;
        rsp_sum_d  = s1_q.exact ? e_sum : a_sum;
        rsp_cout_d = s1_q.exact ? e_cout : a_cout;
        rsp_err_d  = core_err;
      end
    end
    if (s1_load) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_d.id    = gnt_id;
        s1_d.a     = req_a_i[gnt_id*WIDTH +: WIDTH];
        s1_d.b     = req_b_i[gnt_id*WIDTH +: WIDTH];
        s1_d.cin   = req_cin_i[gnt_id];
        s1_d.exact = req_exact_i[gnt_id];
        ptr_d      = gnt_id;
      end
    end
    if (err_clr_i) err_cnt_d = '0;
    else if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s1_vld_q    <= 1'b0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_vld_q    <= s1_vld_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign rsp_err_o   = rsp_err_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: doc/ppa_adder_arbiter.md
# ppa_adder_arbiter

Shares one 16-bit approximate Brent-Kung adder core among NUM_REQ requesters through a round-robin arbiter and a two-stage valid/ready pipeline. Each request selects either the approximate result (lower carry chain truncated at APPROX_K) or the exact result. A saturating counter records how often the approximate result differed from the exact one. The block sits between the operand sources and the accuracy-evaluation / result-consumer logic of the adder test system.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand width
- APPROX_K, 8, bit index where approximate carry propagation restarts (1..WIDTH-1)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_cin  in  NUM_REQ  carry-in (used in exact mode only)
- req_exact  in  NUM_REQ  1 = exact sum, 0 = approximate sum
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  clog2(NUM_REQ)  requester index of response
- rsp_sum  out  WIDTH  selected sum
- rsp_cout  out  1  selected carry-out
- rsp_err  out  1  approximate op whose {cout,sum} differed from exact
- err_clr  in  1  synchronous clear of err_count
- err_count  out  16  saturating count of erroneous approximate ops

## Operation
- Approximate arithmetic (bit j, 0-indexed): p=a^b, g=a&b. Carry into bit 0 is 0 (cin ignored). Carry into bit j for 1≤j≤APPROX_K is g[j-1]. For j>APPROX_K carries ripple exactly, starting from carry into APPROX_K. sum[j]=p[j]^carry_j; cout = exact carry out of bit WIDTH-1 under the same chain.
- Exact arithmetic: {cout,sum} = a+b+cin.
- Arbitration: round-robin. Priority starts at requester ptr+1 (mod NUM_REQ), where ptr is the last granted index. ptr updates only on an accepted request (req_valid&req_ready).
- Stage 1 (S1) register holds valid, id, a, b, cin, exact. S1 loads when the stage is empty or S1 moves to S2 in the same cycle.
- Stage 2 (S2) = rsp_* registers. S2 loads from S1 when !rsp_valid || rsp_ready. The core is evaluated combinationally on S1 contents.
- req_ready[i] = grant[i] && S1 can load. Requests are never dropped. Operands must stay stable while valid && !ready.
- rsp_err = !exact && (approx {cout,sum} != exact {cout,sum}), with exact computed at cin=0. It is always 0 for exact ops.
- err_count increments by 1 when an op with rsp_err=1 loads into S2. It saturates at 0xFFFF. If err_clr and an increment coincide, the result is 0.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_err=0, err_count=0, S1 valid=0, ptr=NUM_REQ-1 (requester 0 has first priority). req_ready is 0 during reset.
- Latency: request accepted at edge N gives rsp_valid=1 after edge N+1 when unstalled, i.e. 2 register stages, response visible in the cycle after the S1 load.
- Throughput: 1 op/cycle with rsp_ready held high.
- Stall: with rsp_ready=0 and both stages full, all req_ready are 0. rsp_* stay stable until the handshake completes.
- Reset mid-operation discards in-flight ops. No response is produced for them.

## Structure
- Package ppa_pkg: WIDTH, APPROX_K, NUM_REQ defaults, ID_W=clog2(NUM_REQ), and the packed S1 payload struct.
- Sub-module bk_approx_core (combinational): inputs a, b, cin. Outputs approx_sum, approx_cout, exact_sum, exact_cout. It uses Brent-Kung prefix nodes above APPROX_K.
- The arbiter, S1/S2 pipeline and err_count live in ppa_adder_arbiter.

## Test plan
- After reset, req0 sends approx A=0x00FF, B=0x0001 → rsp_id=0, sum=0x00FC, cout=0, rsp_err=1, err_count=1.
- Req1 sends exact A=0x00FF, B=0x0001, cin=1 → sum=0x0101, cout=0, rsp_err=0, err_count unchanged.
- Req2 sends approx A=0xFF00, B=0x0100 → sum=0x0000, cout=1, rsp_err=0.
- All 4 requesters valid continuously with rsp_ready=1 → grants rotate 0,1,2,3,0… and one response per cycle.
- rsp_ready=0 for 5 cycles with traffic → two ops buffered, req_ready all 0, rsp_* stable. On release, ops drain in order with none lost or duplicated.
- err_count preset to 0xFFFF via error traffic plus another error → stays 0xFFFF. err_clr coincident with an error → 0. Asserting rst mid-stream → rsp_valid drops to 0 immediately and err_count=0.
